// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game datapath.
// Holds the input-capture state encoding, colour codes and button helpers.
package simon_pkg;

    localparam int unsigned SEQ_W   = 32;
    localparam int unsigned ROUND_W = 4;

    localparam logic [1:0] COL_0 = 2'b00;
    localparam logic [1:0] COL_1 = 2'b01;
    localparam logic [1:0] COL_2 = 2'b10;
    localparam logic [1:0] COL_3 = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StArmed,
        StWaitPress,
        StWaitRelease,
        StSubmit,
        StWaitAck
    } cap_state_t;

    function automatic logic is_onehot(input logic [3:0] b);
        return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] btn_to_code(input logic [3:0] b);
        logic [1:0] code;
        case (b)
            4'b0001: code = COL_0;
            4'b0010: code = COL_1;
            4'b0100: code = COL_2;
            4'b1000: code = COL_3;
            default: code = COL_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for the 4 colour buttons.
// Publishes a pattern only after it has held for DEBOUNCE_CYCLES cycles.
module btn_debounce
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [3:0] btn,
    output logic [3:0] stable,
    output logic       changed
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       prev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            prev_q  <= 4'b0000;
            cnt_q   <= '0;
            stable  <= 4'b0000;
            changed <= 1'b0;
        end else if (clr) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            prev_q  <= 4'b0000;
            cnt_q   <= '0;
            stable  <= 4'b0000;
            changed <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            changed <= 1'b0;
            // cnt_q counts how many consecutive cycles prev_q has been seen
            if (sync2_q != prev_q) begin
                prev_q <= sync2_q;
                cnt_q  <= CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((cnt_q == CNT_MAX) && (stable != prev_q)) begin
                stable  <= prev_q;
                changed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_capture.sv
// Captures the player's debounced colour presses for one round into a packed
// 2-bit-per-colour word and hands it to check_state with a submit pulse.
module input_capture
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 5_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rst_input,
    input  logic               en_input,
    input  logic [ROUND_W-1:0] round_ctr_in,
    input  logic [3:0]         btn,
    input  logic               complete_check,
    output logic [SEQ_W-1:0]   seq_in_check,
    output logic               en_check,
    output logic               input_busy,
    output logic               timeout,
    output logic [3:0]         colour_led
);

    localparam logic [23:0] TIMER_MAX = 24'(TIMEOUT_CYCLES - 1);

    cap_state_t  state_q;
    logic [4:0]  target_q;
    logic [4:0]  count_q;
    logic [23:0] timer_q;
    logic [3:0]  stable;
    logic        changed;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rst_input),
        .btn    (btn),
        .stable (stable),
        .changed(changed)
    );

    assign input_busy = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            target_q     <= 5'd0;
            count_q      <= 5'd0;
            timer_q      <= 24'd0;
            seq_in_check <= '0;
            en_check     <= 1'b0;
            timeout      <= 1'b0;
            colour_led   <= 4'b0000;
        end else if (rst_input) begin
            state_q      <= StIdle;
            target_q     <= 5'd0;
            count_q      <= 5'd0;
            timer_q      <= 24'd0;
            seq_in_check <= '0;
            en_check     <= 1'b0;
            timeout      <= 1'b0;
            colour_led   <= 4'b0000;
        end else begin
            en_check <= 1'b0;
            timeout  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en_input) begin
                        target_q <= {1'b0, round_ctr_in} + 5'd1;
                        state_q  <= StClear;
                    end
                end
                StClear: begin
                    seq_in_check <= '0;
                    count_q      <= 5'd0;
                    timer_q      <= 24'd0;
                    state_q      <= StArmed;
                end
                StArmed: begin
                    // A key still held from the previous round must be released first
                    if (stable == 4'b0000) begin
                        state_q <= StWaitPress;
                    end
                end
                StWaitPress: begin
                    if (changed && is_onehot(stable)) begin
                        seq_in_check[{count_q[3:0], 1'b0} +: 2] <= btn_to_code(stable);
                        count_q    <= count_q + 5'd1;
                        colour_led <= stable;
                        timer_q    <= 24'd0;
                        state_q    <= StWaitRelease;
                    end else if (timer_q == TIMER_MAX) begin
                        timeout <= 1'b1;
                        timer_q <= 24'd0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 24'd1;
                    end
                end
                StWaitRelease: begin
                    if (stable == 4'b0000) begin
                        colour_led <= 4'b0000;
                        if (count_q == target_q) begin
                            en_check <= 1'b1;
                            state_q  <= StSubmit;
                        end else begin
                            state_q <= StWaitPress;
                        end
                    end
                end
                StSubmit: begin
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (complete_check) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
